if_fetch: RTL and testbench
===========================

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter NOP_INSTR, 32'h0000_0013, instruction presented when no valid instruction.
REQ-003 clk  input  1  clock, all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 stall_f  input  1  downstream IF/ID register stalled; fetch outputs must hold.
REQ-006 redirect  input  1  branch/jump taken; restart fetch at redirect_pc.
REQ-007 redirect_pc  input  32  new fetch address; bits [1:0] ignored, treated as 0.
REQ-008 imem_req  output  1  instruction memory request.
REQ-009 imem_addr  output  32  request word address, valid while imem_req=1.
REQ-010 imem_gnt  input  1  request accepted this cycle when imem_req=1.
REQ-011 imem_rvalid  input  1  read data valid; at most one per accepted request, at least 1 cycle after grant.
REQ-012 imem_rdata  input  32  instruction word, valid with imem_rvalid.
REQ-013 instr_f  output  32  fetched instruction to IF/ID register (registered).
REQ-014 pc_f  output  32  address of instr_f (registered).
REQ-015 pcplus4_f  output  32  pc_f + 4, modulo 2^32.
REQ-016 valid_f  output  1  instr_f/pc_f hold a real instruction (registered).

Function
REQ-017 The block SHALL hold at most one outstanding memory request.
REQ-018 The block SHALL implement states REQ (issuing), WAIT (awaiting rvalid), HOLD (response buffered behind stall), DRAIN (discarding killed response).
REQ-019 In REQ: imem_req=1, imem_addr=fetch_pc; on imem_gnt: pending_pc<=fetch_pc, fetch_pc<=fetch_pc+4, go WAIT; else stay REQ.
REQ-020 In WAIT with imem_rvalid=1 and stall_f=0: outputs load {imem_rdata, pending_pc, valid=1}; imem_req=1 in the same cycle at fetch_pc (back-to-back); gnt -> stay WAIT with new pending_pc, else -> REQ.
REQ-021 In WAIT with imem_rvalid=1 and stall_f=1: response captured into a one-entry skid buffer, outputs hold, go HOLD, imem_req=0.
REQ-022 In HOLD: imem_req=0; when stall_f=0, outputs load skid entry with valid_f=1, go REQ.
REQ-023 Any cycle with stall_f=0 and no instruction loaded: instr_f<=NOP_INSTR, valid_f<=0, pc_f holds.
REQ-024 Any cycle with stall_f=1 and redirect=0: instr_f, pc_f, valid_f SHALL hold.
REQ-025 Zero-wait memory (gnt same cycle, rvalid next cycle) SHALL sustain one valid_f per cycle after the first.
REQ-026 redirect SHALL take priority over stall_f, rvalid and gnt: fetch_pc<=redirect_pc; valid_f<=0; instr_f<=NOP_INSTR; skid cleared; imem_req=0 that cycle.
REQ-027 Redirect with a request outstanding and no rvalid this cycle (WAIT) SHALL go DRAIN; redirect in REQ while imem_gnt=1 SHALL also go DRAIN (killed grant).
REQ-028 Redirect otherwise (REQ without gnt, HOLD, WAIT with rvalid same cycle) SHALL go REQ; that rvalid data is dropped.
REQ-029 In DRAIN: imem_req=0; on imem_rvalid, data discarded, go REQ; redirect in DRAIN updates fetch_pc, stays DRAIN.
REQ-030 Address arithmetic SHALL wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0).

Reset
REQ-031 While reset=1: state=REQ, fetch_pc=RESET_PC, pending_pc=0, skid empty, instr_f=NOP_INSTR, pc_f=0, valid_f=0, imem_req forced 0.
REQ-032 First cycle after reset deassert: imem_req=1, imem_addr=RESET_PC.
REQ-033 Reset asserted mid-request SHALL abandon it; a stale rvalid arriving in the first cycle after reset is ignored only if state is not WAIT/DRAIN (it is, by REQ-031).

Verification
REQ-034 Zero-wait memory, no stall -> valid_f=1 every cycle from 3rd cycle after reset, pc_f = 0,4,8,12...
REQ-035 gnt delayed 3 cycles -> imem_addr stable at 0x0 with imem_req=1 for 4 cycles, no duplicate or skipped pc_f.
REQ-036 stall_f=1 for 5 cycles while rvalid returns pc 0x8 -> outputs hold pc 0x4 instruction, then pc 0x8 delivered once with valid_f=1.
REQ-037 redirect to 0x100 while request for 0xC outstanding -> response for 0xC discarded (DRAIN), next imem_addr=0x100, next valid pc_f=0x100.
REQ-038 redirect and stall_f same cycle -> valid_f=0, instr_f=0x00000013 next cycle; redirect_pc=0x203 fetches 0x200.
REQ-039 fetch_pc=0xFFFF_FFFC -> next imem_addr=0x0, pcplus4_f=0x0 when pc_f=0xFFFF_FFFC.

Source files
------------

// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch -- instruction fetch stage with a single outstanding memory request
//
// Issues word-aligned requests to an instruction memory with a request/grant,
// read-valid handshake. It keeps at most one request in flight and presents
// the fetched word to the IF/ID register. A one-entry skid buffer holds a
// response that arrives while the stage is stalled. Redirects kill the
// in-flight work. A response that is already granted but not yet returned is
// drained and discarded.
//
// Ports:
//   clk, reset         clock; asynchronous active-high reset
//   stall_f            IF/ID register stalled; fetch outputs hold
//   redirect           taken branch/jump; restart fetch at redirect_pc
//   redirect_pc[31:0]  new fetch address (bits [1:0] ignored)
//   imem_req/imem_addr request and word address to instruction memory
//   imem_gnt           request accepted this cycle
//   imem_rvalid/rdata  read response (one per accepted request)
//   instr_f/pc_f       fetched instruction and its address (registered)
//   pcplus4_f          pc_f + 4
//   valid_f            instr_f/pc_f hold a real instruction (registered)
// ---------------------------------------------------------------------------
module if_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_f,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_f,
    output logic [31:0] pc_f,
    output logic [31:0] pcplus4_f,
    output logic        valid_f
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,   // issuing a request at fetch_pc
        S_WAIT  = 2'd1,   // request granted, awaiting rvalid
        S_HOLD  = 2'd2,   // response parked in the skid buffer behind a stall
        S_DRAIN = 2'd3    // granted response was killed by a redirect
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] pending_pc_q, pending_pc_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic        req_d;
    logic [31:0] redirect_word;

    // Redirect targets are forced to a word boundary.
    assign redirect_word = redirect_pc & ~32'h0000_0003;

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        pending_pc_d = pending_pc_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        instr_d      = instr_q;
        pc_d         = pc_q;
        valid_d      = valid_q;
        req_d        = 1'b0;

        // An unstalled cycle that loads nothing presents a bubble; pc_f holds.
        if (!stall_f) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end

        if (redirect) begin
            // Redirect overrides stall, rvalid and grant. Leaving HOLD
            // implicitly empties the skid buffer.
            fetch_pc_d = redirect_word;
            instr_d    = NOP_INSTR;
            valid_d    = 1'b0;
            case (state_q)
                S_WAIT:  state_d = imem_rvalid ? S_REQ : S_DRAIN;
                // The memory may have accepted the request this cycle; its
                // response must be swallowed.
                S_REQ:   state_d = imem_gnt ? S_DRAIN : S_REQ;
                // If the killed response lands in the same cycle as a further
                // redirect it is consumed, so there is nothing left to drain.
                S_DRAIN: state_d = imem_rvalid ? S_REQ : S_DRAIN;
                default: state_d = S_REQ;
            endcase
        end else begin
            case (state_q)
                S_REQ: begin
                    req_d = 1'b1;
                    if (imem_gnt) begin
                        pending_pc_d = fetch_pc_q;
                        fetch_pc_d   = fetch_pc_q + 32'd4;
                        state_d      = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (!stall_f) begin
                            instr_d = imem_rdata;
                            pc_d    = pending_pc_q;
                            valid_d = 1'b1;
                            // Back-to-back request keeps zero-wait memory at
                            // one instruction per cycle.
                            req_d   = 1'b1;
                            if (imem_gnt) begin
                                pending_pc_d = fetch_pc_q;
                                fetch_pc_d   = fetch_pc_q + 32'd4;
                                state_d      = S_WAIT;
                            end else begin
                                state_d = S_REQ;
                            end
                        end else begin
                            skid_instr_d = imem_rdata;
                            skid_pc_d    = pending_pc_q;
                            state_d      = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall_f) begin
                        instr_d = skid_instr_q;
                        pc_d    = skid_pc_q;
                        valid_d = 1'b1;
                        state_d = S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (imem_rvalid) begin
                        state_d = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_REQ;
            fetch_pc_q   <= RESET_PC;
            pending_pc_q <= 32'd0;
            skid_instr_q <= 32'd0;
            skid_pc_q    <= 32'd0;
            instr_q      <= NOP_INSTR;
            pc_q         <= 32'd0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            pending_pc_q <= pending_pc_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            instr_q      <= instr_d;
            pc_q         <= pc_d;
            valid_q      <= valid_d;
        end
    end

    // The request is a function of the current-cycle handshake so that a
    // response and the next request can share a cycle; reset masks it.
    assign imem_req  = req_d & ~reset;
    assign imem_addr = fetch_pc_q;
    assign instr_f   = instr_q;
    assign pc_f      = pc_q;
    assign valid_f   = valid_q;
    assign pcplus4_f = pc_q + 32'd4;

endmodule

// File: tb/tb_if_fetch.sv
// ---------------------------------------------------------------------------
// tb_if_fetch -- directed self-checking bench for if_fetch
//
// A small memory responder grants when enabled and returns rvalid one cycle
// after a grant unless held off. Each returned word is its address XOR
// 32'hA5A5_0000, so the expected instruction follows from the expected pc.
// ---------------------------------------------------------------------------
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall_f = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr_f;
    logic [31:0] pc_f;
    logic [31:0] pcplus4_f;
    logic        valid_f;

    logic        gnt_en = 1'b1;
    logic        rsp_hold = 1'b0;
    logic        pend = 1'b0;
    logic [31:0] pend_addr = 32'd0;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    if_fetch dut (
        .clk         (clk),
        .reset       (reset),
        .stall_f     (stall_f),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_f     (instr_f),
        .pc_f        (pc_f),
        .pcplus4_f   (pcplus4_f),
        .valid_f     (valid_f)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Memory responder: one outstanding read, data one cycle after grant.
    assign imem_gnt    = imem_req & gnt_en;
    assign imem_rvalid = pend & ~rsp_hold;
    assign imem_rdata  = pend ? mem_word(pend_addr) : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (reset) begin
            pend <= 1'b0;
        end else begin
            if (imem_rvalid) pend <= 1'b0;
            if (imem_req && imem_gnt) begin
                pend      <= 1'b1;
                pend_addr <= imem_addr;
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset for two edges and release it; returns inside cycle 1.
    task automatic start(input logic ge);
        reset       = 1'b1;
        stall_f     = 1'b0;
        redirect    = 1'b0;
        rsp_hold    = 1'b0;
        redirect_pc = 32'd0;
        gnt_en      = ge;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
    endtask

    initial begin
        // ---- reset state ----
        step();
        check_val("rst_req",   32'(imem_req), 32'd0);
        check_val("rst_valid", 32'(valid_f),  32'd0);
        check_val("rst_instr", instr_f,       NOP);
        check_val("rst_pc",    pc_f,          32'd0);
        check_val("rst_pc4",   pcplus4_f,     32'd4);
        $display("txn reset: req=%0b valid=%0b instr=%h pc=%h", imem_req, valid_f, instr_f, pc_f);

        // ---- zero-wait streaming ----
        start(1'b1);
        check_val("zw_c1_req",  32'(imem_req), 32'd1);
        check_val("zw_c1_addr", imem_addr,     32'd0);
        step();
        check_val("zw_c2_valid", 32'(valid_f), 32'd0);
        step();
        for (int i = 0; i < 4; i++) begin
            check_val("zw_valid", 32'(valid_f), 32'd1);
            check_val("zw_pc",    pc_f,         32'(4 * i));
            check_val("zw_instr", instr_f,      mem_word(32'(4 * i)));
            check_val("zw_pc4",   pcplus4_f,    32'(4 * i + 4));
            $display("txn stream: pc=%h instr=%h valid=%0b", pc_f, instr_f, valid_f);
            step();
        end

        // ---- stall while response for 0x8 returns ----
        start(1'b1);
        step(); step(); step();                       // cycle 4
        check_val("st_pc4_before", pc_f, 32'h4);
        stall_f = 1'b1;
        #1;
        check_val("st_req_off", 32'(imem_req), 32'd0);
        for (int i = 0; i < 4; i++) begin             // cycles 5..8
            step();
            check_val("st_hold_pc",    pc_f,         32'h4);
            check_val("st_hold_valid", 32'(valid_f), 32'd1);
            check_val("st_hold_instr", instr_f,      mem_word(32'h4));
            check_val("st_hold_req",   32'(imem_req), 32'd0);
        end
        step();                                       // cycle 9
        stall_f = 1'b0;
        #1;
        check_val("st_rel_req", 32'(imem_req), 32'd0);
        check_val("st_rel_pc",  pc_f,          32'h4);
        step();                                       // cycle 10
        check_val("st_deliv_pc",    pc_f,          32'h8);
        check_val("st_deliv_valid", 32'(valid_f),  32'd1);
        check_val("st_deliv_instr", instr_f,       mem_word(32'h8));
        check_val("st_next_addr",   imem_addr,     32'hC);
        check_val("st_next_req",    32'(imem_req), 32'd1);
        step();                                       // cycle 11
        check_val("st_once_valid", 32'(valid_f), 32'd0);
        check_val("st_once_pc",    pc_f,         32'h8);
        check_val("st_once_instr", instr_f,      NOP);
        step();                                       // cycle 12
        check_val("st_c_pc",    pc_f,         32'hC);
        check_val("st_c_valid", 32'(valid_f), 32'd1);
        $display("txn stall: pc=%h valid=%0b", pc_f, valid_f);

        // ---- grant delayed 3 cycles ----
        start(1'b0);
        for (int i = 0; i < 3; i++) begin             // cycles 1..3
            check_val("gd_req",   32'(imem_req), 32'd1);
            check_val("gd_addr",  imem_addr,     32'd0);
            check_val("gd_valid", 32'(valid_f),  32'd0);
            step();
        end
        gnt_en = 1'b1;                                // cycle 4
        #1;
        check_val("gd_req4",  32'(imem_req), 32'd1);
        check_val("gd_addr4", imem_addr,     32'd0);
        step();
        check_val("gd_c5_valid", 32'(valid_f), 32'd0);
        step();
        check_val("gd_c6_pc",    pc_f,         32'h0);
        check_val("gd_c6_valid", 32'(valid_f), 32'd1);
        step();
        check_val("gd_c7_pc",    pc_f,         32'h4);
        check_val("gd_c7_valid", 32'(valid_f), 32'd1);
        $display("txn gnt_delay: pc=%h valid=%0b", pc_f, valid_f);

        // ---- redirect with request for 0xC outstanding ----
        start(1'b1);
        step(); step(); step(); step();               // cycle 5
        check_val("rd_pc_before", pc_f, 32'h8);
        rsp_hold    = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        #1;
        check_val("rd_req_off", 32'(imem_req), 32'd0);
        step();                                       // cycle 6: drain
        redirect = 1'b0;
        rsp_hold = 1'b0;
        #1;
        check_val("rd_drain_valid", 32'(valid_f),  32'd0);
        check_val("rd_drain_instr", instr_f,       NOP);
        check_val("rd_drain_pc",    pc_f,          32'h8);
        check_val("rd_drain_req",   32'(imem_req), 32'd0);
        step();                                       // cycle 7
        check_val("rd_new_req",   32'(imem_req), 32'd1);
        check_val("rd_new_addr",  imem_addr,     32'h100);
        check_val("rd_new_valid", 32'(valid_f),  32'd0);
        step();
        check_val("rd_c8_valid", 32'(valid_f), 32'd0);
        step();
        check_val("rd_c9_pc",    pc_f,         32'h100);
        check_val("rd_c9_valid", 32'(valid_f), 32'd1);
        check_val("rd_c9_instr", instr_f,      mem_word(32'h100));
        $display("txn redirect: pc=%h instr=%h valid=%0b", pc_f, instr_f, valid_f);

        // ---- redirect and stall in the same cycle, unaligned target ----
        start(1'b1);
        step(); step(); step();                       // cycle 4
        stall_f     = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0203;
        #1;
        check_val("rs_req_off", 32'(imem_req), 32'd0);
        step();                                       // cycle 5
        redirect = 1'b0;
        #1;
        check_val("rs_valid", 32'(valid_f),  32'd0);
        check_val("rs_instr", instr_f,       NOP);
        check_val("rs_pc",    pc_f,          32'h4);
        check_val("rs_req",   32'(imem_req), 32'd1);
        check_val("rs_addr",  imem_addr,     32'h200);
        step();                                       // cycle 6
        stall_f = 1'b0;
        #1;
        step();                                       // cycle 7
        check_val("rs_new_pc",    pc_f,         32'h200);
        check_val("rs_new_valid", 32'(valid_f), 32'd1);
        check_val("rs_new_instr", instr_f,      mem_word(32'h200));
        $display("txn redirect_stall: pc=%h valid=%0b", pc_f, valid_f);

        // ---- address wrap at 0xFFFF_FFFC ----
        start(1'b1);
        step();                                       // cycle 2
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        #1;
        check_val("wr_req_off", 32'(imem_req), 32'd0);
        step();                                       // cycle 3
        redirect = 1'b0;
        #1;
        check_val("wr_req",  32'(imem_req), 32'd1);
        check_val("wr_addr", imem_addr,     32'hFFFF_FFFC);
        step();                                       // cycle 4
        check_val("wr_wrap_addr", imem_addr,     32'h0);
        check_val("wr_wrap_req",  32'(imem_req), 32'd1);
        check_val("wr_c4_valid",  32'(valid_f),  32'd0);
        step();                                       // cycle 5
        check_val("wr_top_pc",    pc_f,         32'hFFFF_FFFC);
        check_val("wr_top_pc4",   pcplus4_f,    32'h0);
        check_val("wr_top_valid", 32'(valid_f), 32'd1);
        check_val("wr_top_instr", instr_f,      mem_word(32'hFFFF_FFFC));
        step();                                       // cycle 6
        check_val("wr_zero_pc",  pc_f,      32'h0);
        check_val("wr_zero_pc4", pcplus4_f, 32'h4);
        $display("txn wrap: pc=%h pc4=%h", pc_f, pcplus4_f);

        // ---- reset asserted mid-request ----
        step();
        reset = 1'b1;
        #1;
        check_val("mr_req",   32'(imem_req), 32'd0);
        check_val("mr_valid", 32'(valid_f),  32'd0);
        check_val("mr_pc",    pc_f,          32'd0);
        start(1'b1);
        check_val("mr_restart_addr", imem_addr,     32'd0);
        check_val("mr_restart_req",  32'(imem_req), 32'd1);
        $display("txn mid_reset: req=%0b addr=%h", imem_req, imem_addr);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
